// File: rtl/down_counter_timer_pkg.sv
// Shared constants and state type for the down_counter_timer block.
package down_counter_timer_pkg;

   localparam int DCT_WIDTH_DEFAULT = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } dct_state_e;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with a terminal-count pulse and IDLE/RUN sequencing.
// Define DOWN_COUNTER_TIMER_AUTORELOAD_EN to make the count reload on expiry instead of stopping.
//
// state | meaning
// IDLE  | stopped; ena ignored, result held (0 after reset or expiry)
// RUN   | counting down on each ena=1 edge; expiry at result==1
module down_counter_timer
   import down_counter_timer_pkg::*;
#(
   parameter int WIDTH = DCT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ena,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             tc
);

   dct_state_e       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         busy_q   <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         tc_q     <= tc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (load) begin
         // Load wins over a same-cycle expiry, so no tc is generated.
         count_d  = load_val;
         reload_d = load_val;
         state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
      end else if (state_q == ST_RUN && ena) begin
         if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
         end else if (count_q == WIDTH'(1)) begin
            tc_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            count_d = reload_q;
            state_d = ST_RUN;
`else
            count_d = '0;
            state_d = ST_IDLE;
`endif
         end else begin
            // Zero count in RUN is unreachable; fall back to IDLE rather than wrap.
            count_d = '0;
            state_d = ST_IDLE;
         end
      end

      busy_d = (state_d == ST_RUN);
   end

   assign result = count_q;
   assign busy   = busy_q;
   assign tc     = tc_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer.
module tb_down_counter_timer;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         ena;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] result;
   logic         busy;
   logic         tc;

   int errors = 0;
   int checks = 0;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .ena      (ena),
      .load     (load),
      .load_val (load_val),
      .result   (result),
      .busy     (busy),
      .tc       (tc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] r, input logic b, input logic t);
      chk({tag, ".result"}, 32'(result), 32'(r));
      chk({tag, ".busy"},   32'(busy),   32'(b));
      chk({tag, ".tc"},     32'(tc),     32'(t));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      ena      = 1'b0;
      load     = 1'b0;
      load_val = '0;
      #7;
      chk_all("rst", 8'd0, 1'b0, 1'b0);
      #3;
      reset = 1'b0;

      // idle after reset: ena ignored
      ena = 1'b1;
      tick(); chk_all("idle0", 8'd0, 1'b0, 1'b0);
      tick(); chk_all("idle1", 8'd0, 1'b0, 1'b0);

      // load 3 and count to expiry
      load = 1'b1; load_val = 8'd3;
      tick(); chk_all("l3.a", 8'd3, 1'b1, 1'b0);
      load = 1'b0;
      tick(); chk_all("l3.b", 8'd2, 1'b1, 1'b0);
      tick(); chk_all("l3.c", 8'd1, 1'b1, 1'b0);
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
      tick(); chk_all("l3.d", 8'd3, 1'b1, 1'b1);
      tick(); chk_all("l3.e", 8'd2, 1'b1, 1'b0);
`else
      tick(); chk_all("l3.d", 8'd0, 1'b0, 1'b1);
      tick(); chk_all("l3.e", 8'd0, 1'b0, 1'b0);
`endif

      // ena toggling holds count
      load = 1'b1; load_val = 8'd5; ena = 1'b1;
      tick(); chk_all("l5.a", 8'd5, 1'b1, 1'b0);
      load = 1'b0;
      tick(); chk_all("l5.b", 8'd4, 1'b1, 1'b0);
      ena = 1'b0;
      tick(); chk_all("l5.c", 8'd4, 1'b1, 1'b0);
      ena = 1'b1;
      tick(); chk_all("l5.d", 8'd3, 1'b1, 1'b0);

      // async reset mid-count
      load = 1'b1; load_val = 8'd4;
      tick(); chk_all("l4.a", 8'd4, 1'b1, 1'b0);
      load = 1'b0;
      tick(); chk_all("l4.b", 8'd3, 1'b1, 1'b0);
      tick(); chk_all("l4.c", 8'd2, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk_all("arst", 8'd0, 1'b0, 1'b0);
      #1;
      reset = 1'b0;
      tick(); chk_all("arst.idle0", 8'd0, 1'b0, 1'b0);
      tick(); chk_all("arst.idle1", 8'd0, 1'b0, 1'b0);

      // load beats expiry
      load = 1'b1; load_val = 8'd2;
      tick(); chk_all("pri.a", 8'd2, 1'b1, 1'b0);
      load = 1'b0;
      tick(); chk_all("pri.b", 8'd1, 1'b1, 1'b0);
      load = 1'b1; load_val = 8'd7;
      tick(); chk_all("pri.c", 8'd7, 1'b1, 1'b0);
      load = 1'b0;
      tick(); chk_all("pri.d", 8'd6, 1'b1, 1'b0);

      // load zero: idle, no tc, no wrap
      load = 1'b1; load_val = 8'd0;
      tick(); chk_all("z.a", 8'd0, 1'b0, 1'b0);
      load = 1'b0;
      tick(); chk_all("z.b", 8'd0, 1'b0, 1'b0);
      tick(); chk_all("z.c", 8'd0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
      // periodic reload with period 2
      load = 1'b1; load_val = 8'd2;
      tick(); chk_all("ar.0", 8'd2, 1'b1, 1'b0);
      load = 1'b0;
      tick(); chk_all("ar.1", 8'd1, 1'b1, 1'b0);
      tick(); chk_all("ar.2", 8'd2, 1'b1, 1'b1);
      tick(); chk_all("ar.3", 8'd1, 1'b1, 1'b0);
      tick(); chk_all("ar.4", 8'd2, 1'b1, 1'b1);
      tick(); chk_all("ar.5", 8'd1, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_down_counter_timer

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter WIDTH, default 8, counter/load width in bits.
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
REQ-004 ena  input  1  count enable; decrement permitted only while high.
REQ-005 load  input  1  synchronous load strobe for load_val.
REQ-006 load_val  input  WIDTH  start/reload count value.
REQ-007 result  output  WIDTH  current count, registered.
REQ-008 busy  output  1  high while state is RUN, registered.
REQ-009 tc  output  1  terminal-count pulse, one clk wide, registered.

Function
REQ-010 States SHALL be IDLE and RUN; reset state SHALL be IDLE.
REQ-011 load=1 in any state SHALL capture load_val into result and into an internal reload register at the next edge.
REQ-012 load with load_val!=0 SHALL enter RUN; load with load_val==0 SHALL enter IDLE with result=0 and tc=0.
REQ-013 load SHALL have priority over ena, including in the cycle expiry would otherwise occur; tc SHALL stay 0 in that case.
REQ-014 In RUN with ena=1, load=0, result>1: result SHALL decrement by 1 per edge.
REQ-015 In RUN with ena=1, load=0, result==1: expiry SHALL occur; tc=1 for exactly the following cycle.
REQ-016 ena=0 SHALL hold result and state unchanged; tc=0.
REQ-017 In IDLE, ena SHALL be ignored; result SHALL hold its value.
REQ-018 Latency: result change and tc SHALL appear one edge after the qualifying inputs are sampled.
REQ-019 result SHALL never wrap below 0; no decrement from 0 in any mode.
REQ-020 busy SHALL equal (state==RUN) and be registered with the state.

Reset
REQ-021 reset=1 SHALL force result=0, busy=0, tc=0, reload register=0, state=IDLE asynchronously, mid-count included.
REQ-022 After reset deasserts, the block SHALL remain IDLE until the first load.

Configuration
REQ-023 Macro DOWN_COUNTER_TIMER_AUTORELOAD_EN SHALL select the expiry behaviour.
REQ-024 Defined: on expiry result SHALL reload from the reload register, state SHALL stay RUN, tc pulses once per period (period = load_val cycles of ena=1).
REQ-025 Undefined: on expiry result SHALL become 0, state SHALL go IDLE, busy SHALL drop with tc.

Structure
REQ-026 Package down_counter_timer_pkg SHALL hold the WIDTH default constant and the IDLE/RUN state type.
REQ-027 No sub-module; single flat module with one state register, count register, reload register.

Verification
REQ-028 Reset high 10 ns, load_val=3 load pulse, ena=1 -> result 3,2,1,0; tc=1 in the cycle result=0; busy low after (macro off).
REQ-029 Macro on, load_val=2, ena=1 held 6 cycles -> result 2,1,2,1,2,1; tc pulses when result returns to 2; busy stays 1.
REQ-030 load_val=5, ena toggled 1,0,1 -> result 5,4,4,3; tc=0 throughout.
REQ-031 load_val=4, reset asserted mid-count at result=2 between edges -> result=0, busy=0 immediately; ena ignored until next load.
REQ-032 result=1, ena=1 and load=1 with load_val=7 same cycle -> result=7, tc=0, busy=1.
REQ-033 load with load_val=0, ena=1 -> result=0, busy=0, tc never asserted.
